// File: rtl/mul_share_pkg.sv
// Shared state encoding and default widths for the shared-multiplier arbiter.
package mul_share_pkg;

  localparam int unsigned DefaultN       = 32;
  localparam int unsigned DefaultTimeout = 128;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  index,
  output logic            any_req
);

  logic [IDW-1:0] cand;

  always_comb begin
    grant   = '0;
    index   = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (enable && !any_req && req[cand]) begin
        any_req     = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one sequential multiplier between NREQ requesters with round-robin grant,
// a single tagged response port and a watchdog that turns a hung multiply into an error.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int unsigned N       = DefaultN,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = DefaultTimeout,
  localparam int unsigned IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              mul_start,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_b,
  input  logic              mul_done,
  input  logic [2*N-1:0]    mul_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned WDW = $clog2(TIMEOUT);

  state_e          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  id_q;
  logic [WDW-1:0]  wdog_q;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            any_req;
  logic [N-1:0]    a_slice [NREQ];
  logic [N-1:0]    b_slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_slice[i] = req_a[i*N +: N];
    assign b_slice[i] = req_b[i*N +: N];
  end

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .enable (state_q == StIdle),
    .grant  (gnt),
    .index  (gnt_idx),
    .any_req(any_req)
  );

  assign req_ready = gnt;
  assign rsp_id    = id_q;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      wdog_q    <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            mul_a     <= a_slice[gnt_idx];
            mul_b     <= b_slice[gnt_idx];
            id_q      <= gnt_idx;
            rr_ptr_q  <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            mul_start <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          wdog_q  <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A done arriving on the last allowed cycle still counts as success.
          if (mul_done) begin
            rsp_data  <= mul_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed and randomized bench for mul_share_arbiter with a behavioural multiplier and
// a reference model of grant order, product, error and response latency.
module tb_mul_share_arbiter;

  localparam int N       = 32;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 128;
  localparam int IDW     = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              mul_start;
  logic [N-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic              mul_done;
  logic [2*N-1:0]    mul_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*N-1:0]    rsp_data;
  logic              rsp_err;
  logic              busy;

  int compared   = 0;
  int mismatched = 0;

  // Reference state: round-robin pointer and requester operands.
  int           m_ptr = 0;
  logic [N-1:0] op_a [NREQ];
  logic [N-1:0] op_b [NREQ];

  // Behavioural multiplier state.
  bit           m_never = 1'b0;
  bit           m_pend  = 1'b0;
  int           m_cnt   = 0;
  int           m_lat   = 1;
  int           starts  = 0;
  logic [N-1:0] m_a;
  logic [N-1:0] m_b;

  mul_share_arbiter #(
    .N      (N),
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_result(mul_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and run the multiplier model there.
  task automatic tick();
    @(negedge clk);
    mul_done   = 1'b0;
    mul_result = {$urandom, $urandom};
    if (m_pend) begin
      if (m_cnt <= 1) begin
        mul_done   = 1'b1;
        mul_result = {32'b0, m_a} * {32'b0, m_b};
        m_pend     = 1'b0;
      end else begin
        m_cnt--;
      end
    end
    if (mul_start) begin
      starts++;
      m_a    = mul_a;
      m_b    = mul_b;
      m_pend = !m_never;
      m_cnt  = m_lat;
    end
  endtask

  task automatic run_op(input logic [NREQ-1:0] add, input int lat, input bit never,
                        input int bp, input bit fix, input logic [N-1:0] fa,
                        input logic [N-1:0] fb, output int gout);
    int g;
    int w;
    int st0;
    int exp_w;
    logic [2*N-1:0] exp_data;
    bit exp_err;
    for (int i = 0; i < NREQ; i++) begin
      if (add[i] && !req_valid[i]) begin
        op_a[i] = fix ? fa : N'($urandom);
        op_b[i] = fix ? fb : N'($urandom);
        req_a[i*N +: N] = op_a[i];
        req_b[i*N +: N] = op_b[i];
        req_valid[i] = 1'b1;
      end
    end
    m_lat   = lat;
    m_never = never;
    // Lowest valid index at or above the pointer, otherwise lowest valid overall.
    g = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (req_valid[i] && i >= m_ptr) g = i;
    if (g < 0) for (int i = NREQ - 1; i >= 0; i--) if (req_valid[i]) g = i;
    if (g < 0) g = 0;
    exp_err  = never || (lat > TIMEOUT);
    exp_data = exp_err ? '0 : {32'b0, op_a[g]} * {32'b0, op_b[g]};
    exp_w    = (exp_err ? TIMEOUT : lat) + 1;
    st0 = starts;
    #1;
    w = 0;
    while (req_ready == '0 && w < 8) begin
      tick();
      #1;
      w++;
    end
    chk("grant", req_ready, 64'(1) << g);
    tick();
    req_valid[g] = 1'b0;
    #1;
    chk("ready_after_grant", req_ready, 0);
    chk("busy_in_op", busy, 1);
    chk("start_pulse", starts - st0, 1);
    m_ptr = (g + 1) % NREQ;
    w = 0;
    while (!rsp_valid && w < 400) begin
      tick();
      w++;
    end
    chk("rsp_latency", w, exp_w);
    chk("rsp_id", rsp_id, g);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", rsp_err, exp_err);
    for (int k = 0; k < bp; k++) begin
      tick();
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, exp_data);
      chk("bp_id", rsp_id, g);
      chk("bp_ready", req_ready, 0);
    end
    chk("single_start", starts - st0, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("idle_not_busy", busy, 0);
    gout = g;
  endtask

  initial begin
    int g;
    int st0;
    bit saw;
    logic [NREQ-1:0] add;

    reset      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    mul_done   = 1'b0;
    mul_result = '0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    reset = 1'b1;

    // Single request, 7*6 from requester 1.
    run_op(4'b0010, 33, 1'b0, 0, 1'b1, 32'd7, 32'd6, g);
    // Hung multiplier, then a normal operation.
    run_op(4'b0001, 10, 1'b1, 0, 1'b0, '0, '0, g);
    run_op(4'b1000, 5, 1'b0, 0, 1'b0, '0, '0, g);
    // Backpressure with a second requester waiting, then drain it.
    run_op(4'b0110, 10, 1'b0, 10, 1'b0, '0, '0, g);
    run_op(4'b0000, 3, 1'b0, 0, 1'b0, '0, '0, g);

    // Reset while waiting on the multiplier; its late done must be ignored.
    req_valid[2]    = 1'b1;
    req_a[2*N +: N] = N'($urandom);
    req_b[2*N +: N] = N'($urandom);
    m_lat   = 100;
    m_never = 1'b0;
    #1;
    for (int w = 0; w < 8 && req_ready == '0; w++) begin
      tick();
      #1;
    end
    tick();
    req_valid = '0;
    repeat (20) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_start", mul_start, 0);
    tick();
    reset = 1'b1;
    m_ptr = 0;
    st0   = starts;
    saw   = 1'b0;
    for (int k = 0; k < 120; k++) begin
      tick();
      saw |= rsp_valid;
    end
    chk("stale_done_no_rsp", saw, 0);
    chk("stale_done_idle", busy, 0);
    chk("stale_done_no_start", starts - st0, 0);

    // Fairness: all four requesters kept valid across eight operations.
    run_op(4'b1111, 4, 1'b0, 0, 1'b0, '0, '0, g);
    for (int k = 0; k < 7; k++) begin
      add = '0;
      add[g] = 1'b1;
      run_op(add, $urandom_range(1, 12), 1'b0, 0, 1'b0, '0, '0, g);
    end
    for (int k = 0; k < 3; k++) run_op(4'b0000, 2, 1'b0, 0, 1'b0, '0, '0, g);

    // Done on the same cycle the watchdog expires.
    run_op(4'b0001, TIMEOUT, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, g);

    // Randomized traffic.
    for (int k = 0; k < 12; k++) begin
      add = NREQ'($urandom_range(0, 15));
      if ((req_valid | add) == '0) add[$urandom_range(0, NREQ - 1)] = 1'b1;
      run_op(add, $urandom_range(1, 40), ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
             1'b0, '0, '0, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one sequential shift-accumulate multiplier between NREQ requesters.
- Round-robin arbitration; only one multiply in flight at a time.
- Per-requester valid/ready operand ports; a single tagged response port carries the result and requester id.
- A watchdog counter detects a multiplier that never asserts done and returns an error response.

Parameters:
- N, 32, operand width; product is 2*N.
- NREQ, 4, number of requesters (2..16).
- TIMEOUT, 128, max cycles allowed from mul_start to mul_done before error.
- IDW, $clog2(NREQ), requester id width (derived localparam).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*N  packed multiplicands, slice i = requester i
- req_b  in  NREQ*N  packed multipliers
- mul_start  out  1  one-cycle pulse launching the multiplier
- mul_a  out  N  operand A to multiplier, held stable while busy
- mul_b  out  N  operand B to multiplier, held stable while busy
- mul_done  in  1  one-cycle pulse, result valid
- mul_result  in  2*N  multiplier product
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester that issued the operation
- rsp_data  out  2*N  product; zero on error
- rsp_err  out  1  watchdog expired for this operation
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, all outputs 0, watchdog counter=0.
  - Reset mid-operation abandons the in-flight multiply; a late mul_done is ignored because the FSM is in IDLE.
- State IDLE:
  - If any req_valid, grant the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - Same cycle: req_ready[g]=1 (combinational from grant, only in IDLE). Capture req_a/req_b slice g into mul_a/mul_b and g into id_reg.
  - Set rr_ptr = (g+1) mod NREQ, then go to ISSUE.
  - With no valid requests, stay in IDLE and leave rr_ptr unchanged.
- State ISSUE: mul_start=1 for exactly this cycle; clear watchdog; go to WAIT.
- State WAIT:
  - Watchdog increments each cycle.
  - mul_done=1: capture mul_result into rsp_data, rsp_err=0, go to RESP.
  - Watchdog reaches TIMEOUT-1 without done: rsp_data=0, rsp_err=1, go to RESP.
  - Done and timeout in the same cycle: done wins.
- State RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE (rsp_valid drops next cycle).
  - mul_done while in RESP or IDLE is ignored.
- Throughput: minimum 4 cycles of overhead per operation beyond multiplier latency (IDLE grant, ISSUE, done capture, RESP).
- req_ready is never asserted outside IDLE. Requesters hold req_valid and their operands until accepted.
- mul_a/mul_b change only on a grant, so they are stable from ISSUE through RESP.
- Sign handling belongs to the multiplier; the arbiter passes operands and product unmodified.

Decomposition:
- Shared package mul_share_pkg:
  - State encoding localparams IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - Default widths N=32, TIMEOUT=128.
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, encoded index, any_req.
  - Purely combinational; rr_ptr register lives in the parent.

Test Plan:
- Single request: req_valid=4'b0010, a=7, b=6, multiplier model done after 33 cycles -> one mul_start pulse; rsp_id=1, rsp_data=42, rsp_err=0; req_ready[1] high for one cycle only.
- Fairness: all four req_valid held high for 8 operations -> grant order 0,1,2,3,0,1,2,3; each rsp_id matches, and rr_ptr wraps 3->0.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_id/rsp_data stable; req_ready stays 0 and no new mul_start until the rsp_ready handshake.
- Watchdog: model never asserts done, TIMEOUT=128 -> rsp_valid after 128 WAIT cycles with rsp_err=1, rsp_data=0; the next request proceeds normally.
- Reset mid-operation: assert reset=0 in WAIT, release, then model pulses stale mul_done -> no rsp_valid; busy=0; rr_ptr=0.
- Done-at-timeout edge: mul_done in the exact cycle the watchdog hits TIMEOUT-1, product 0xFFFF_FFFE_0000_0001 (a=b=0xFFFF_FFFF) -> rsp_err=0, rsp_data=0xFFFFFFFE00000001.
